// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master: the loader (consumes the stream, drives the memory write port).
// slave : the environment (drives the stream, observes the write port).
interface imem_stream_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       instr;

  modport master (
    input  in_valid, in_data,
    output in_ready, wr_en, waddr, instr
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, wr_en, waddr, instr
  );
endinterface

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: assembles a little-endian byte stream (4-byte word count
// header followed by the body words) into 32-bit instructions, writes them to
// instruction memory and releases the core reset once the program is loaded.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing 4-byte checksum
// (sum mod 2^32 of the body words) that must match before the core is released.
module imem_stream_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_stream_loader_if.master bus,
  output logic                 o_core_rst_n,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  localparam state_t S_TAIL = S_CSUM;
`else
  typedef enum logic [2:0] {S_HDR, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t            r_state;
  state_t            w_nextState;
  logic              r_live;
  logic [1:0]        r_byteIdx;
  logic [23:0]       r_shift;
  logic [31:0]       r_n;
  logic [31:0]       r_wordCnt;
  logic              r_wrEn;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_instr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       r_sum;
`endif

  logic              w_inReady;
  logic              w_accept;
  logic              w_lastByte;
  logic [31:0]       w_word;

  assign w_accept   = bus.in_valid && w_inReady;
  assign w_lastByte = w_accept && (r_byteIdx == 2'd3);
  // Earlier bytes sit in r_shift with the oldest at the bottom, so the
  // incoming byte completes the word as its most significant byte.
  assign w_word     = {bus.in_data, r_shift};

  assign bus.in_ready = w_inReady;
  assign bus.wr_en    = r_wrEn;
  assign bus.waddr    = r_waddr;
  assign bus.instr    = r_instr;

  // State register; reset always restarts at the header.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_HDR;
    else        r_state <= w_nextState;
  end

  // Next-state logic; DATA leaves only once the final word's write cycle is on the bus.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_HDR: begin
        if (w_lastByte) begin
          if (w_word > 32'(DEPTH))  w_nextState = S_ERR;
          else if (w_word == 32'd0) w_nextState = S_TAIL;
          else                      w_nextState = S_DATA;
        end
      end
      S_DATA: begin
        if (r_wordCnt == r_n) w_nextState = S_TAIL;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_lastByte) w_nextState = (w_word == r_sum) ? S_DONE : S_ERR;
      end
`endif
      default: w_nextState = r_state;
    endcase
  end

  // Output decode; r_live keeps the header state quiet for the cycle after reset.
  always_comb begin
    w_inReady    = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    o_core_rst_n = 1'b0;
    case (r_state)
      S_HDR: begin
        w_inReady = r_live;
        o_busy    = r_live;
      end
      S_DATA: begin
        w_inReady = (r_wordCnt != r_n);
        o_busy    = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        w_inReady = 1'b1;
        o_busy    = 1'b1;
      end
`endif
      S_DONE: begin
        o_done       = 1'b1;
        o_core_rst_n = 1'b1;
      end
      S_ERR: begin
        o_err = 1'b1;
      end
      default: begin
        w_inReady = 1'b0;
      end
    endcase
  end

  // Marks the first cycle after reset deasserts so the stream can start.
  always_ff @(posedge clk) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // Byte assembly, header capture, word counter and the one-cycle write pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byteIdx <= 2'd0;
      r_shift   <= 24'd0;
      r_n       <= 32'd0;
      r_wordCnt <= 32'd0;
      r_wrEn    <= 1'b0;
      r_waddr   <= '0;
      r_instr   <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum     <= 32'd0;
`endif
    end else begin
      r_wrEn <= 1'b0;
      if (w_accept) begin
        r_shift   <= w_word[31:8];
        r_byteIdx <= r_byteIdx + 2'd1;
      end
      if (w_lastByte && (r_state == S_HDR)) begin
        r_n <= w_word;
      end
      if (w_lastByte && (r_state == S_DATA)) begin
        r_wrEn    <= 1'b1;
        r_waddr   <= r_wordCnt[ADDR_W-1:0];
        r_instr   <= w_word;
        r_wordCnt <= r_wordCnt + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum     <= r_sum + w_word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Testbench for imem_stream_loader: randomized byte streams against a
// behavioural model of the expected memory writes and final load outcome.
module tb_imem_stream_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic coreRstN;
  logic busy;
  logic done;
  logic err;

  imem_stream_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_stream_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .o_core_rst_n (coreRstN),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } write_t;

  int                assertCount = 0;
  int                failCount   = 0;
  bit                checking    = 1'b0;
  write_t            expWrites[$];
  logic [31:0]       words[$];
  logic [ADDR_W-1:0] lastAddr = '0;
  int                writesSeen = 0;
  write_t            wExp;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s (bound expired or unexpected event)", name);
  endtask

  function automatic logic [31:0] bytesToWord(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
    return 32'(b0) + (32'(b1) * 32'd256) + (32'(b2) * 32'd65536) + (32'(b3) * 32'd16777216);
  endfunction

  // Per-cycle comparison of the write port and status flags against the model.
  always @(negedge clk) begin
    if (checking && rst_n) begin
      checkOutput("doneErrExclusive", 32'(done && err), 32'd0);
      checkOutput("coreRstFollowsDone", 32'(coreRstN), 32'(done));
      if (bus.wr_en === 1'b1) begin
        writesSeen++;
        if (expWrites.size() == 0) begin
          reportFail("unexpectedWrite");
        end else begin
          wExp = expWrites.pop_front();
          checkOutput("waddr", 32'(bus.waddr), 32'(wExp.addr));
          checkOutput("instr", bus.instr, wExp.data);
          lastAddr = wExp.addr;
        end
      end else begin
        checkOutput("waddrHold", 32'(bus.waddr), 32'(lastAddr));
      end
    end
  end

  // Offers one byte after an optional random idle gap (junk data while invalid).
  task automatic applyStimulus(input logic [7:0] b, input int gapPct, input int maxIdle, output bit accepted);
    int idle = 0;
    accepted = 1'b0;
    while ((idle < maxIdle) && (int'($urandom_range(99)) < gapPct)) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      idle++;
      @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int budget = 0; budget < 40 && !accepted; budget++) begin
      if (bus.in_ready === 1'b1) accepted = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int gapPct, input int maxIdle, inout bit aborted);
    bit acc;
    for (int i = 0; i < 4; i++) begin
      if (aborted) return;
      applyStimulus(8'(w >> (8 * i)), gapPct, maxIdle, acc);
      if (!acc) begin
        reportFail("byteAcceptTimeout");
        aborted = 1'b1;
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (2) @(negedge clk);
    lastAddr = '0;
    expWrites.delete();
    checkOutput("rstInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("rstWrEn", 32'(bus.wr_en), 32'd0);
    checkOutput("rstWaddr", 32'(bus.waddr), 32'd0);
    checkOutput("rstInstr", bus.instr, 32'd0);
    checkOutput("rstCoreRstN", 32'(coreRstN), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    rst_n    = 1'b1;
    checking = 1'b1;
  endtask

  // Sends a complete load of n words (body taken from 'words', padded randomly)
  // and checks the outcome the format rules dictate.
  task automatic runLoad(input logic [31:0] n, input int gapPct, input int maxIdle, input logic [31:0] csumDelta);
    logic [31:0] sum = 32'd0;
    bit          aborted = 1'b0;
    bit          expDone;
    int          nBody;
    int          readyCnt = 0;
    nBody = (n <= 32'(DEPTH)) ? int'(n) : 0;
    while (words.size() < nBody) words.push_back($urandom);
    expWrites.delete();
    writesSeen = 0;
    for (int i = 0; i < nBody; i++) begin
      expWrites.push_back('{addr: ADDR_W'(i), data: words[i]});
      sum += words[i];
    end
    expDone = (n <= 32'(DEPTH));
`ifdef IMEM_LOADER_CHECKSUM_EN
    expDone = expDone && (csumDelta == 32'd0);
`endif
    sendWord(n, gapPct, maxIdle, aborted);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (n == 32'd0 && !aborted) checkOutput("doneRightAfterHeaderN0", 32'(done), 32'd1);
`endif
    for (int i = 0; i < nBody; i++) sendWord(words[i], gapPct, maxIdle, aborted);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (nBody > 0 || n == 32'd0) sendWord(sum + csumDelta, gapPct, maxIdle, aborted);
`else
    if (csumDelta != 32'd0) $display("[TB] checksum delta %0d unused in this build", csumDelta);
`endif
    for (int c = 0; c < 20 && !(done || err); c++) @(negedge clk);
    checkOutput("finalDone", 32'(done), 32'(expDone));
    checkOutput("finalErr", 32'(err), 32'(!expDone));
    checkOutput("finalCoreRstN", 32'(coreRstN), 32'(expDone));
    checkOutput("finalBusy", 32'(busy), 32'd0);
    checkOutput("writesRemaining", 32'(expWrites.size()), 32'd0);
    checkOutput("writeCount", 32'(writesSeen), 32'(nBody));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    for (int c = 0; c < 4; c++) begin
      if (bus.in_ready !== 1'b0) readyCnt++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checkOutput("extraBytesRefused", 32'(readyCnt), 32'd0);
  endtask

  initial begin
    bit aborted;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;

    $display("[TB] directed three-word program");
    words.delete();
    words.push_back(bytesToWord(8'h13, 8'h00, 8'h50, 8'h00));
    words.push_back(bytesToWord(8'h93, 8'h00, 8'h10, 8'h00));
    words.push_back(bytesToWord(8'h33, 8'h81, 8'h00, 8'h00));
    checkOutput("modelWord0", words[0], 32'h00500013);
    checkOutput("modelWord1", words[1], 32'h00100093);
    checkOutput("modelWord2", words[2], 32'h00008133);
    applyReset();
    runLoad(32'd3, 0, 0, 32'd0);

    $display("[TB] same program, in_valid alternating");
    applyReset();
    runLoad(32'd3, 100, 1, 32'd0);

    $display("[TB] oversized headers");
    applyReset();
    runLoad(bytesToWord(8'h01, 8'h01, 8'h00, 8'h00), 0, 0, 32'd0);
    applyReset();
    runLoad(32'h8000_0001, 20, 2, 32'd0);

    $display("[TB] empty program");
    applyReset();
    runLoad(32'd0, 0, 0, 32'd0);

    $display("[TB] reset in the middle of a load");
    applyReset();
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    expWrites.delete();
    writesSeen = 0;
    for (int i = 0; i < 2; i++) expWrites.push_back('{addr: ADDR_W'(i), data: words[i]});
    aborted = 1'b0;
    sendWord(32'd3, 30, 2, aborted);
    for (int i = 0; i < 2; i++) sendWord(words[i], 30, 2, aborted);
    for (int c = 0; c < 10 && expWrites.size() != 0; c++) @(negedge clk);
    checkOutput("partialWriteCount", 32'(writesSeen), 32'd2);
    checkOutput("partialNotDone", 32'(done), 32'd0);
    applyReset();
    words.delete();
    words.push_back(bytesToWord(8'hAA, 8'hBB, 8'hCC, 8'hDD));
    checkOutput("modelWordReload", words[0], 32'hDDCCBBAA);
    runLoad(32'd1, 0, 0, 32'd0);

    $display("[TB] full-depth program");
    applyReset();
    words.delete();
    runLoad(32'(DEPTH), 0, 0, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum match and mismatch");
    applyReset();
    words.delete();
    words.push_back(32'd1);
    words.push_back(32'd2);
    runLoad(32'd2, 0, 0, 32'd0);
    applyReset();
    runLoad(32'd2, 0, 0, 32'd1);
`endif

    $display("[TB] randomized programs");
    for (int t = 0; t < 8; t++) begin
      applyReset();
      words.delete();
      runLoad(32'($urandom_range(1, 12)), int'($urandom_range(0, 60)), 3,
              ($urandom_range(3) == 0) ? 32'($urandom_range(1, 255)) : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Global bound so a stuck design still reaches the summary line.
  initial begin
    #900000;
    reportFail("globalTimeout");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
